// File: rtl/axis_fifo_pkg.sv
// Shared types and constants for the AXIS sync FIFO and the AXIS<->FIFO bridge.
package axis_fifo_pkg;

  localparam int AXIS_DATA_WIDTH = 32;
  localparam int FIFO_ADDR_WIDTH = 4;

  // Returns ceil(log2(value)).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  localparam int FIFO_COUNT_WIDTH = clog2((1 << FIFO_ADDR_WIDTH) + 1);

  typedef logic [FIFO_ADDR_WIDTH:0]    ptr_t;
  typedef logic [FIFO_COUNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer with increment enable; the extra MSB toggles on every wrap of the address bits.
module fifo_ptr #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                i_inc,
  output logic [ADDR_WIDTH:0] o_ptr,
  output logic [ADDR_WIDTH:0] o_ptr_next
);

  logic [ADDR_WIDTH:0] r_ptr;

  // Plain binary increment carries out of the address bits into the wrap bit.
  assign o_ptr_next = r_ptr + (ADDR_WIDTH+1)'(i_inc);
  assign o_ptr      = r_ptr;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_ptr <= '0;
    else          r_ptr <= o_ptr_next;
  end

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock FWFT FIFO with registered flags, reject pulses and write-through head bypass.
// Optional fifo_count output enabled by defining AXIS_SYNC_FIFO_COUNT_EN.
module axis_sync_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = AXIS_DATA_WIDTH,
  parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
  parameter int AFULL_LEVEL  = 14,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                  fifo_wr_en,
  output logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_en,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_reject,
  output logic                  rd_reject
`ifdef AXIS_SYNC_FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   fifo_count
`endif
);

  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_empty, r_full, r_aempty, r_afull, r_wr_reject, r_rd_reject;

  logic                  w_push_ok, w_pop_ok;
  logic [ADDR_WIDTH:0]   w_wr_ptr, w_wr_ptr_next, w_rd_ptr, w_rd_ptr_next, w_count_next;

  assign w_push_ok = fifo_wr_en & ~r_full;
  assign w_pop_ok  = fifo_rd_en & ~r_empty;

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .i_inc      (w_push_ok),
    .o_ptr      (w_wr_ptr),
    .o_ptr_next (w_wr_ptr_next)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .i_inc      (w_pop_ok),
    .o_ptr      (w_rd_ptr),
    .o_ptr_next (w_rd_ptr_next)
  );

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop_ok)      w_count_next = r_count + ONE_C;
    else if (!w_push_ok && w_pop_ok) w_count_next = r_count - ONE_C;
  end

  always_ff @(posedge aclk) begin
    if (w_push_ok) r_mem[w_wr_ptr[ADDR_WIDTH-1:0]] <= fifo_wr_data;
  end

  // When the word being written becomes the head, bypass the memory so it shows on the same edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_data <= '0;
    end else if (w_push_ok && (w_rd_ptr_next == w_wr_ptr)) begin
      r_rd_data <= fifo_wr_data;
    end else begin
      r_rd_data <= r_mem[w_rd_ptr_next[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_aempty    <= 1'b1;
      r_afull     <= 1'b0;
      r_wr_reject <= 1'b0;
      r_rd_reject <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      r_empty     <= (w_wr_ptr_next == w_rd_ptr_next);
      r_full      <= (w_wr_ptr_next[ADDR_WIDTH-1:0] == w_rd_ptr_next[ADDR_WIDTH-1:0]) &&
                     (w_wr_ptr_next[ADDR_WIDTH] != w_rd_ptr_next[ADDR_WIDTH]);
      r_aempty    <= (w_count_next <= AEMPTY_C);
      r_afull     <= (w_count_next >= AFULL_C);
      r_wr_reject <= fifo_wr_en & r_full;
      r_rd_reject <= fifo_rd_en & r_empty;
    end
  end

  assign fifo_rd_data = r_rd_data;
  assign fifo_empty   = r_empty;
  assign fifo_full    = r_full;
  assign almost_empty = r_aempty;
  assign almost_full  = r_afull;
  assign wr_reject    = r_wr_reject;
  assign rd_reject    = r_rd_reject;
`ifdef AXIS_SYNC_FIFO_COUNT_EN
  assign fifo_count   = r_count;
`endif

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Self-checking bench for axis_sync_fifo: directed scenarios plus random traffic against a queue model.
// Checks fifo_count too when AXIS_SYNC_FIFO_COUNT_EN is defined.
module tb_axis_sync_fifo;

  localparam int DEPTH = 16;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] fifoWrData = '0;
  logic        fifoWrEn = 1'b0;
  logic        fifoRdEn = 1'b0;
  logic        fifoFull, fifoEmpty, almostFull, almostEmpty, wrReject, rdReject;
  logic [31:0] fifoRdData;
`ifdef AXIS_SYNC_FIFO_COUNT_EN
  logic [4:0]  fifoCount;
`endif

  logic [31:0] model[$];
  int          checkCount = 0;
  int          passCount = 0;

  always #5 aclk = ~aclk;

  axis_sync_fifo dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .fifo_wr_data (fifoWrData),
    .fifo_wr_en   (fifoWrEn),
    .fifo_full    (fifoFull),
    .fifo_rd_data (fifoRdData),
    .fifo_rd_en   (fifoRdEn),
    .fifo_empty   (fifoEmpty),
    .almost_full  (almostFull),
    .almost_empty (almostEmpty),
    .wr_reject    (wrReject),
    .rd_reject    (rdReject)
`ifdef AXIS_SYNC_FIFO_COUNT_EN
    ,
    .fifo_count   (fifoCount)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
  endtask

  // Compare every DUT output with what the queue model says should be visible now.
  task automatic checkState(input logic expWrReject, input logic expRdReject);
    int n;
    n = model.size();
    checkOutput("fifo_empty", 32'(fifoEmpty), 32'(n == 0));
    checkOutput("fifo_full", 32'(fifoFull), 32'(n == DEPTH));
    checkOutput("almost_empty", 32'(almostEmpty), 32'(n <= 2));
    checkOutput("almost_full", 32'(almostFull), 32'(n >= 14));
    checkOutput("wr_reject", 32'(wrReject), 32'(expWrReject));
    checkOutput("rd_reject", 32'(rdReject), 32'(expRdReject));
    if (n > 0) checkOutput("fifo_rd_data", fifoRdData, model[0]);
`ifdef AXIS_SYNC_FIFO_COUNT_EN
    checkOutput("fifo_count", 32'(fifoCount), 32'(n));
`endif
  endtask

  // One clock of traffic: drive, advance the model on the edge, then check just after it.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] data);
    int  sizeBefore;
    logic pushOk, popOk;
    fifoWrEn   = wr;
    fifoRdEn   = rd;
    fifoWrData = data;
    @(posedge aclk);
    sizeBefore = model.size();
    pushOk = wr && (sizeBefore < DEPTH);
    popOk  = rd && (sizeBefore > 0);
    if (popOk) void'(model.pop_front());
    if (pushOk) model.push_back(data);
    #1;
    fifoWrEn = 1'b0;
    fifoRdEn = 1'b0;
    checkState(wr && !pushOk, rd && !popOk);
  endtask

  task automatic checkReset();
    checkOutput("rst_empty", 32'(fifoEmpty), 32'd1);
    checkOutput("rst_full", 32'(fifoFull), 32'd0);
    checkOutput("rst_almost_empty", 32'(almostEmpty), 32'd1);
    checkOutput("rst_almost_full", 32'(almostFull), 32'd0);
    checkOutput("rst_wr_reject", 32'(wrReject), 32'd0);
    checkOutput("rst_rd_reject", 32'(rdReject), 32'd0);
    checkOutput("rst_rd_data", fifoRdData, 32'd0);
`ifdef AXIS_SYNC_FIFO_COUNT_EN
    checkOutput("rst_count", 32'(fifoCount), 32'd0);
`endif
  endtask

  initial begin
    #12;
    checkReset();
    aresetn = 1'b1;
    #10;

    // Single push into an empty FIFO.
    applyStimulus(1'b1, 1'b0, 32'hA5A5_0001);
    checkOutput("t1_head", fifoRdData, 32'hA5A5_0001);
    applyStimulus(1'b0, 1'b1, 32'h0);

    // Fill to full, then one extra push that must be rejected.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 32'(i));
    checkOutput("t2_full", 32'(fifoFull), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'hDEAD_0017);
    checkOutput("t2_reject", 32'(wrReject), 32'd1);
    checkOutput("t2_head_kept", fifoRdData, 32'd0);

    // Push and pop together while full.
    applyStimulus(1'b1, 1'b1, 32'hDEAD_0018);
    checkOutput("t3_next_head", fifoRdData, 32'd1);

    while (model.size() > 0) applyStimulus(1'b0, 1'b1, 32'h0);

    // Push and pop together while empty.
    applyStimulus(1'b1, 1'b1, 32'h55);
    checkOutput("t4_head", fifoRdData, 32'h55);
    applyStimulus(1'b0, 1'b1, 32'h0);

    // Streaming through the pointer wrap with a single word in flight.
    applyStimulus(1'b1, 1'b0, 32'd0);
    for (int i = 1; i < 40; i++) applyStimulus(1'b1, 1'b1, 32'(i));
    checkOutput("t5_last_head", fifoRdData, 32'd39);
    applyStimulus(1'b0, 1'b1, 32'h0);

    // Asynchronous reset mid-stream discards stored data.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 32'h7000 + 32'(i));
    #3;
    aresetn = 1'b0;
    model.delete();
    #1;
    checkReset();
    #8;
    aresetn = 1'b1;
    #10;
    applyStimulus(1'b1, 1'b0, 32'hBEEF);
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("t6_empty_after", 32'(fifoEmpty), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'hBEEF);
    checkOutput("t6_head", fifoRdData, 32'hBEEF);
    applyStimulus(1'b0, 1'b1, 32'h0);

    // Random traffic with phases biased toward filling and draining.
    for (int phase = 0; phase < 6; phase++) begin
      int wrPct;
      int rdPct;
      wrPct = (phase % 2 == 0) ? 80 : 25;
      rdPct = (phase % 2 == 0) ? 25 : 80;
      for (int c = 0; c < 60; c++) begin
        applyStimulus(1'($urandom_range(0, 99) < wrPct), 1'($urandom_range(0, 99) < rdPct), $urandom);
      end
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
